// File: rtl/gf24_mul_seq_if.sv
// Operand/product handshake bundle for the GF(2^24) sequential multiplier.
// slave = multiplier side, master = requester/consumer side.
interface gf24_mul_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_a;
   logic [23:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_p;
   logic        busy;

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p, busy
   );

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p, busy
   );
endinterface

// File: rtl/gf24_mul_seq.sv
// Iterative GF(2^24) multiplier: 12 Horner steps of two multiplier bits,
// MSB digit first, reduced by x^24 + POLY_TAPS.
module gf24_mul_seq #(
   parameter logic [23:0] POLY_TAPS = 24'h00001B
) (
   input logic           clk,
   input logic           rst_n,
   gf24_mul_seq_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [23:0] a_q, a_d;
   logic [23:0] b_q, b_d;
   logic [23:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [23:0] pp;
   logic [1:0]  dig;

   function automatic logic [23:0] mulx(input logic [23:0] v);
      return {v[22:0], 1'b0} ^ (v[23] ? POLY_TAPS : 24'h000000);
   endfunction

   // partial product of the current top digit of the multiplier
   always_comb begin
      dig = b_q[23:22];
      pp  = (dig[1] ? mulx(a_q) : 24'h000000)
          ^ (dig[0] ? a_q : 24'h000000);
   end

   // sequencing: accept, 12 Horner steps, hold result until consumed
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               acc_d   = 24'h000000;
               cnt_d   = 4'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = mulx(mulx(acc_q)) ^ pp;
            b_d   = {b_q[21:0], 2'b00};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd11) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= 24'h000000;
         b_q     <= 24'h000000;
         acc_q   <= 24'h000000;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign bus.out_p     = acc_q;

endmodule
